// File: rtl/gpio_in_conditioner_pkg.sv
// Shared GPIO definitions: init sequencer states and default geometry
// constants used by the input conditioner and by the SoC top.
package pck_gpio;

  // Default synchroniser depth and debounce counter width.
  localparam int GPIO_SYNC_STAGES = 2;
  localparam int GPIO_CNT_WIDTH   = 16;

  // Boot sequencing: fill the synchroniser, load the level once, then run.
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } init_state_e;

endpackage

// File: rtl/gpio_in_conditioner_bit_filter.sv
// One GPIO pin: metastability synchroniser, optional debounce counter,
// conditioned level register and registered edge pulses.
module gpio_bit_filter
  import pck_gpio::*;
#(
  parameter int p_sync_stages = GPIO_SYNC_STAGES,
  parameter int p_cnt_width   = GPIO_CNT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_pin,
  input  logic                   i_filter_en,
  input  logic [p_cnt_width-1:0] i_debounce_limit,
  input  logic                   i_prime,
  input  logic                   i_run,
  output logic                   o_level,
  output logic                   o_rise,
  output logic                   o_fall
);

  localparam logic [p_cnt_width-1:0] CNT_ZERO = {p_cnt_width{1'b0}};
  localparam logic [p_cnt_width-1:0] CNT_ONE  = {{(p_cnt_width-1){1'b0}}, 1'b1};
  localparam logic [p_cnt_width-1:0] CNT_MAX  = {p_cnt_width{1'b1}};

  logic [p_sync_stages-1:0] sync_r;
  logic                     sync_s;
  logic [p_cnt_width-1:0]   cnt_r;
  logic [p_cnt_width-1:0]   cnt_nxt_s;
  logic                     level_r;
  logic                     level_nxt_s;
  logic                     level_d_r;
  logic                     level_d_nxt_s;
  logic                     rise_r;
  logic                     fall_r;

  assign sync_s = sync_r[p_sync_stages-1];

  // Shift the raw pad level through the synchroniser chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_r <= {p_sync_stages{1'b0}};
    end else begin
      sync_r <= {sync_r[p_sync_stages-2:0], i_pin};
    end
  end

  // Next conditioned level and debounce count; >= lets a lowered limit act at once.
  always_comb begin
    level_nxt_s   = level_r;
    cnt_nxt_s     = CNT_ZERO;
    level_d_nxt_s = level_r;
    if (i_prime) begin
      // Load the boot level and its delayed copy together so no edge follows.
      level_nxt_s   = sync_s;
      level_d_nxt_s = sync_s;
    end else if (i_run) begin
      if (!i_filter_en) begin
        level_nxt_s = sync_s;
      end else if (sync_s == level_r) begin
        cnt_nxt_s = CNT_ZERO;
      end else if (cnt_r >= i_debounce_limit) begin
        level_nxt_s = sync_s;
        cnt_nxt_s   = CNT_ZERO;
      end else if (cnt_r == CNT_MAX) begin
        cnt_nxt_s = CNT_MAX;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      level_nxt_s   = level_r;
      level_d_nxt_s = level_d_r;
    end
  end

  // Register level, counter and the delayed level used for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
      cnt_r     <= CNT_ZERO;
    end else begin
      level_r   <= level_nxt_s;
      level_d_r <= level_d_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  // One-cycle edge pulses the cycle after the conditioned level changed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= i_run & level_r & ~level_d_r;
      fall_r <= i_run & ~level_r & level_d_r;
    end
  end

  assign o_level = level_r;
  assign o_rise  = rise_r;
  assign o_fall  = fall_r;

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: per-pin synchronise/debounce/edge-detect, boot
// sequencing that suppresses spurious edges, and latched interrupt flags.
module gpio_in_conditioner
  import pck_gpio::*;
#(
  parameter int p_num_gpios   = 16,
  parameter int p_sync_stages = GPIO_SYNC_STAGES,
  parameter int p_cnt_width   = GPIO_CNT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [p_num_gpios-1:0] i_pins,
  input  logic [p_num_gpios-1:0] i_filter_en,
  input  logic [p_cnt_width-1:0] i_debounce_limit,
  input  logic [p_num_gpios-1:0] i_rise_irq_en,
  input  logic [p_num_gpios-1:0] i_fall_irq_en,
  input  logic [p_num_gpios-1:0] i_irq_clear,
  output logic [p_num_gpios-1:0] o_gpio_in,
  output logic [p_num_gpios-1:0] o_rise,
  output logic [p_num_gpios-1:0] o_fall,
  output logic [p_num_gpios-1:0] o_irq_pending,
  output logic                   o_irq
);

  localparam int INIT_CNT_W = $clog2(p_sync_stages + 1);
  localparam logic [INIT_CNT_W-1:0] INIT_ZERO = {INIT_CNT_W{1'b0}};
  localparam logic [INIT_CNT_W-1:0] INIT_ONE  = {{(INIT_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(p_sync_stages - 1);

  init_state_e             state_r;
  init_state_e             state_nxt_s;
  logic [INIT_CNT_W-1:0]   init_cnt_r;
  logic [INIT_CNT_W-1:0]   init_cnt_nxt_s;
  logic                    prime_s;
  logic                    run_s;
  logic [p_num_gpios-1:0]  level_s;
  logic [p_num_gpios-1:0]  rise_s;
  logic [p_num_gpios-1:0]  fall_s;
  logic [p_num_gpios-1:0]  pend_set_s;
  logic [p_num_gpios-1:0]  pend_r;
  logic                    irq_r;

  // Boot sequencer state and synchroniser-fill counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= INIT;
      init_cnt_r <= INIT_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      init_cnt_r <= init_cnt_nxt_s;
    end
  end

  // Boot sequencer transitions: INIT waits out the synchroniser, PRIME loads once.
  always_comb begin
    state_nxt_s    = state_r;
    init_cnt_nxt_s = init_cnt_r;
    prime_s        = 1'b0;
    run_s          = 1'b0;
    case (state_r)
      INIT: begin
        if (init_cnt_r == INIT_LAST) begin
          state_nxt_s    = PRIME;
          init_cnt_nxt_s = INIT_ZERO;
        end else begin
          init_cnt_nxt_s = init_cnt_r + INIT_ONE;
        end
      end
      PRIME: begin
        prime_s     = 1'b1;
        state_nxt_s = RUN;
      end
      RUN: begin
        run_s       = 1'b1;
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s    = INIT;
        init_cnt_nxt_s = INIT_ZERO;
      end
    endcase
  end

  for (genvar g = 0; g < p_num_gpios; g++) begin : g_pin
    gpio_bit_filter #(
      .p_sync_stages (p_sync_stages),
      .p_cnt_width   (p_cnt_width)
    ) u_bit (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_pin            (i_pins[g]),
      .i_filter_en      (i_filter_en[g]),
      .i_debounce_limit (i_debounce_limit),
      .i_prime          (prime_s),
      .i_run            (run_s),
      .o_level          (level_s[g]),
      .o_rise           (rise_s[g]),
      .o_fall           (fall_s[g])
    );
  end

  assign pend_set_s = (rise_s & i_rise_irq_en) | (fall_s & i_fall_irq_en);

  // Pending flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_r <= {p_num_gpios{1'b0}};
    end else begin
      pend_r <= (pend_r & ~i_irq_clear) | pend_set_s;
    end
  end

  // Interrupt line: registered OR of the pending flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |pend_r;
    end
  end

  assign o_gpio_in     = level_s;
  assign o_rise        = rise_s;
  assign o_fall        = fall_s;
  assign o_irq_pending = pend_r;
  assign o_irq         = irq_r;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Scoreboard bench for gpio_in_conditioner: stimulus pushes expectations
// tagged with the cycle they apply to; monitors pop and compare them.
module tb_gpio_in_conditioner;

  localparam int S_GPIO = 0;
  localparam int S_RISE = 1;
  localparam int S_FALL = 2;
  localparam int S_PEND = 3;
  localparam int S_IRQ  = 4;
  localparam int AT_RST = -1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pins = 16'h0000;
  logic [15:0] filter_en = 16'h0000;
  logic [15:0] limit = 16'd0;
  logic [15:0] rise_en = 16'h0000;
  logic [15:0] fall_en = 16'h0000;
  logic [15:0] clr = 16'h0000;
  logic [15:0] o_gpio_in;
  logic [15:0] o_rise;
  logic [15:0] o_fall;
  logic [15:0] o_irq_pending;
  logic        o_irq;

  typedef struct {
    int          at;
    int          sel;
    logic [15:0] mask;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  gpio_in_conditioner #(
    .p_num_gpios   (16),
    .p_sync_stages (2),
    .p_cnt_width   (16)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_pins           (pins),
    .i_filter_en      (filter_en),
    .i_debounce_limit (limit),
    .i_rise_irq_en    (rise_en),
    .i_fall_irq_en    (fall_en),
    .i_irq_clear      (clr),
    .o_gpio_in        (o_gpio_in),
    .o_rise           (o_rise),
    .o_fall           (o_fall),
    .o_irq_pending    (o_irq_pending),
    .o_irq            (o_irq)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pick(input int sel);
    case (sel)
      S_GPIO:  pick = o_gpio_in;
      S_RISE:  pick = o_rise;
      S_FALL:  pick = o_fall;
      S_PEND:  pick = o_irq_pending;
      S_IRQ:   pick = {15'd0, o_irq};
      default: pick = 16'h0000;
    endcase
  endfunction

  task automatic check_entry(input exp_t e);
    logic [15:0] act;
    act = pick(e.sel) & e.mask;
    n_checks++;
    if (act !== (e.val & e.mask)) begin
      n_fail++;
      $display("FAIL %s (cyc %0d): actual %h required %h", e.name, cyc, act, e.val & e.mask);
    end
  endtask

  // Clocked monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check_entry(sb[i]);
        sb.delete(i);
      end
    end
  end

  // Reset monitor: outputs must clear without waiting for a clock edge.
  always @(negedge rst_n) begin
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == AT_RST) begin
        check_entry(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int dc, input int sel, input logic [15:0] mask,
                           input logic [15:0] val, input string name);
    exp_t e;
    e.at   = (dc < 0) ? AT_RST : cyc + dc;
    e.sel  = sel;
    e.mask = mask;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_quiet_boot(input logic [15:0] level);
    expect_at(2, S_GPIO, 16'hFFFF, 16'h0000, "prime_not_yet");
    expect_at(3, S_GPIO, 16'hFFFF, level, "prime_load");
    for (int k = 1; k <= 8; k++) begin
      expect_at(k, S_RISE, 16'hFFFF, 16'h0000, "boot_no_rise");
      expect_at(k, S_FALL, 16'hFFFF, 16'h0000, "boot_no_fall");
      expect_at(k, S_PEND, 16'hFFFF, 16'h0000, "boot_no_pend");
      expect_at(k, S_IRQ,  16'h0001, 16'h0000, "boot_no_irq");
    end
  endtask

  initial begin
    int guard;
    // Reset held with a pattern on the pads; every interrupt enable on.
    pins    = 16'h00A5;
    rise_en = 16'hFFFF;
    fall_en = 16'hFFFF;
    tick(3);
    expect_at(1, S_GPIO, 16'hFFFF, 16'h0000, "rst_gpio");
    expect_at(1, S_IRQ,  16'h0001, 16'h0000, "rst_irq");
    tick(2);
    rst_n = 1'b1;
    expect_quiet_boot(16'h00A5);
    tick(10);

    // Unfiltered rising edge on pin 3 with its rise interrupt enabled.
    rise_en = 16'h0008;
    fall_en = 16'h0000;
    tick(1);
    pins = pins | 16'h0008;
    expect_at(2, S_GPIO, 16'h0008, 16'h0000, "p3_before");
    expect_at(3, S_GPIO, 16'h0008, 16'h0008, "p3_level");
    expect_at(3, S_RISE, 16'h0008, 16'h0000, "p3_rise_early");
    expect_at(4, S_RISE, 16'h0008, 16'h0008, "p3_rise");
    expect_at(5, S_RISE, 16'h0008, 16'h0000, "p3_rise_end");
    expect_at(4, S_PEND, 16'h0008, 16'h0000, "p3_pend_early");
    expect_at(5, S_PEND, 16'h0008, 16'h0008, "p3_pend");
    expect_at(5, S_IRQ,  16'h0001, 16'h0000, "p3_irq_early");
    expect_at(6, S_IRQ,  16'h0001, 16'h0001, "p3_irq");
    tick(8);
    clr = 16'h0008;
    expect_at(1, S_PEND, 16'h0008, 16'h0000, "p3_cleared");
    expect_at(2, S_IRQ,  16'h0001, 16'h0000, "p3_irq_cleared");
    tick(1);
    clr = 16'h0000;
    tick(5);

    // Pin 5 low unfiltered, then debounce with limit 10.
    pins = pins & ~16'h0020;
    expect_at(4, S_GPIO, 16'h0020, 16'h0000, "p5_low");
    tick(6);
    filter_en = 16'h0020;
    limit     = 16'd10;
    tick(2);
    pins = pins | 16'h0020;
    for (int k = 1; k <= 20; k++) begin
      expect_at(k, S_GPIO, 16'h0020, 16'h0000, "glitch_level");
      expect_at(k, S_RISE, 16'h0020, 16'h0000, "glitch_rise");
    end
    tick(8);
    pins = pins & ~16'h0020;
    tick(14);
    pins = pins | 16'h0020;
    expect_at(12, S_GPIO, 16'h0020, 16'h0000, "deb_not_yet");
    expect_at(13, S_GPIO, 16'h0020, 16'h0020, "deb_level");
    expect_at(14, S_RISE, 16'h0020, 16'h0020, "deb_rise");
    expect_at(15, S_RISE, 16'h0020, 16'h0000, "deb_rise_end");
    tick(25);

    // Limit lowered from 100 to 4 once the counter has reached 50.
    limit = 16'd100;
    tick(1);
    pins = pins & ~16'h0020;
    expect_at(52, S_GPIO, 16'h0020, 16'h0020, "lim_hold");
    expect_at(53, S_GPIO, 16'h0020, 16'h0000, "lim_lowered");
    expect_at(54, S_FALL, 16'h0020, 16'h0020, "lim_fall");
    tick(52);
    limit = 16'd4;
    tick(8);

    // Pin 2: pending from a rise, then a clear coinciding with a fall event.
    limit   = 16'd100;
    rise_en = 16'h0004;
    fall_en = 16'h0000;
    tick(1);
    pins = pins & ~16'h0004;
    expect_at(5, S_PEND, 16'h0004, 16'h0000, "p2_fall_masked");
    tick(8);
    pins = pins | 16'h0004;
    expect_at(4, S_RISE, 16'h0004, 16'h0004, "p2_rise");
    expect_at(5, S_PEND, 16'h0004, 16'h0004, "p2_pend_rise");
    tick(2);
    fall_en = 16'h0004;
    tick(6);
    pins = pins & ~16'h0004;
    expect_at(3, S_GPIO, 16'h0004, 16'h0000, "p2_low");
    expect_at(4, S_FALL, 16'h0004, 16'h0004, "p2_fall");
    expect_at(5, S_PEND, 16'h0004, 16'h0004, "set_wins");
    expect_at(6, S_PEND, 16'h0004, 16'h0004, "set_wins_hold");
    expect_at(7, S_IRQ,  16'h0001, 16'h0001, "set_wins_irq");
    tick(4);
    clr = 16'h0004;
    tick(1);
    clr = 16'h0000;
    tick(5);
    clr = 16'h0004;
    expect_at(1, S_PEND, 16'h0004, 16'h0000, "p2_cleared");
    expect_at(1, S_IRQ,  16'h0001, 16'h0001, "irq_lag");
    expect_at(2, S_IRQ,  16'h0001, 16'h0000, "irq_cleared");
    tick(1);
    clr = 16'h0000;
    tick(4);

    // Async reset while pin 5 is mid-debounce, then a quiet re-prime.
    pins = pins | 16'h0020;
    tick(9);
    expect_at(-1, S_GPIO, 16'hFFFF, 16'h0000, "arst_gpio");
    expect_at(-1, S_RISE, 16'hFFFF, 16'h0000, "arst_rise");
    expect_at(-1, S_FALL, 16'hFFFF, 16'h0000, "arst_fall");
    expect_at(-1, S_PEND, 16'hFFFF, 16'h0000, "arst_pend");
    expect_at(-1, S_IRQ,  16'h0001, 16'h0000, "arst_irq");
    #2;
    rst_n = 1'b0;
    tick(3);
    rise_en = 16'hFFFF;
    fall_en = 16'hFFFF;
    rst_n   = 1'b1;
    expect_quiet_boot(pins);
    tick(10);

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < sb.size(); i++) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expired, due at cyc %0d, now %0d", sb[i].name, sb[i].at, cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
